// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-side memory responder for the five-stage MIPS core. It answers the
// core's M-stage data requests from a byte-lane word RAM. Reads have one
// cycle of latency, and a write returns its own merged post-write word
// (write-first). Requests outside the RAM are flagged on addr_err.
//
// Optional build macro: DMEM_MMIO_EN
//   When defined, byte addresses whose bits [31:4] match MMIO_BASE[31:4]
//   decode to a small I/O window:
//     +0x0 LED register (read/write, lanes 0-1 only)
//     +0x4 switch inputs (read-only)
//     +0x8 free-running cycle counter (read-only)
//     +0xC reserved (reads 0, raises addr_err)
//   When undefined, there is no window, led_o is tied to 0, and window
//   addresses are simply out of range.
//
// Parameters
//   ADDR_W     word-index width; the RAM holds 2^ADDR_W 32-bit words
//   MMIO_BASE  base byte address of the I/O window
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (drops any request in that cycle)
//   mem_en       request valid
//   mem_wen[3:0] byte-lane write enables; 0 means read
//   mem_addr     byte address; bits [1:0] are ignored
//   mem_wdata    lane-aligned write data
//   mem_rdata    read result, held until the next accepted request
//   rdata_valid  one-cycle pulse after each accepted request
//   addr_err     one-cycle pulse after an out-of-range request
//   led_o        LED register (0 unless DMEM_MMIO_EN is defined)
//   sw_i         switch inputs (ignored unless DMEM_MMIO_EN is defined)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic [15:0] led_o,
    input  logic [15:0] sw_i
);

    localparam int DEPTH = 1 << ADDR_W;

    // Replaces each enabled byte lane of oldWord with the matching lane of newWord.
    function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  laneEn);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = laneEn[i] ? newWord[8*i +: 8] : oldWord[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]       ram [DEPTH];
    logic [ADDR_W-1:0] wordIdx;
    logic              isRam;
    logic              isWrite;
    logic              accept;
    logic [31:0]       oldWord;
    logic [31:0]       mergedWord;

    // Response computed this cycle, registered at the accept edge.
    logic [31:0]       respData_p0;
    logic              respErr_p0;
    logic              ramWe_p0;

    logic [31:0]       rdData_p1;
    logic              rdValid_p1;
    logic              addrErr_p1;

    assign accept     = mem_en && !rst;
    assign isWrite    = |mem_wen;
    assign wordIdx    = mem_addr[ADDR_W+1:2];
    // In range only when every address bit above the word index is zero.
    assign isRam      = (mem_addr >> (ADDR_W + 2)) == 32'd0;
    assign oldWord    = ram[wordIdx];
    // Every request reads its own word, so a write returns the post-write merge.
    assign mergedWord = mergeLanes(oldWord, mem_wdata, mem_wen);

`ifdef DMEM_MMIO_EN
    logic        isMmio;
    logic [1:0]  mmioOff;
    logic [15:0] ledReg;
    logic [15:0] ledMerged;
    logic [31:0] cycleCnt;
    logic        ledWe_p0;
    logic        unusedBits;

    assign isMmio    = mem_addr[31:4] == MMIO_BASE[31:4];
    assign mmioOff   = mem_addr[3:2];
    assign ledMerged = {mem_wen[1] ? mem_wdata[15:8] : ledReg[15:8],
                        mem_wen[0] ? mem_wdata[7:0]  : ledReg[7:0]};
    assign led_o      = ledReg;
    assign unusedBits = ^{mem_addr[1:0], MMIO_BASE[3:0]};

    always_comb begin
        respData_p0 = 32'd0;
        respErr_p0  = 1'b0;
        ramWe_p0    = 1'b0;
        ledWe_p0    = 1'b0;
        if (isMmio) begin
            // The window takes precedence over RAM if the two ever overlap.
            case (mmioOff)
                2'd0: begin
                    respData_p0 = {16'h0, ledMerged};
                    ledWe_p0    = isWrite;
                end
                2'd1:    respData_p0 = {16'h0, sw_i};
                2'd2:    respData_p0 = cycleCnt;
                default: respErr_p0  = 1'b1;
            endcase
        end else if (isRam) begin
            respData_p0 = mergedWord;
            ramWe_p0    = isWrite;
        end else begin
            respErr_p0  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ledReg   <= 16'h0;
            cycleCnt <= 32'd0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if (mem_en && ledWe_p0) begin
                ledReg <= ledMerged;
            end
        end
    end
`else
    logic unusedBits;

    assign led_o      = 16'h0;
    assign unusedBits = ^{mem_addr[1:0], sw_i, MMIO_BASE};

    always_comb begin
        respData_p0 = 32'd0;
        respErr_p0  = 1'b0;
        ramWe_p0    = 1'b0;
        if (isRam) begin
            respData_p0 = mergedWord;
            ramWe_p0    = isWrite;
        end else begin
            respErr_p0  = 1'b1;
        end
    end
`endif

    // RAM write: only enabled lanes change; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && ramWe_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wen[i]) begin
                    ram[wordIdx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---- stage p0 -> p1: response register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_p1  <= 32'd0;
            rdValid_p1 <= 1'b0;
            addrErr_p1 <= 1'b0;
        end else begin
            rdValid_p1 <= mem_en;
            addrErr_p1 <= mem_en && respErr_p0;
            if (mem_en) begin
                rdData_p1 <= respData_p0;
            end
        end
    end

    assign mem_rdata   = rdData_p1;
    assign rdata_valid = rdValid_p1;
    assign addr_err    = addrErr_p1;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side memory responder for the five-stage MIPS core: it sits on the far side of the core's M-stage data port and answers the core's memory requests. Inputs are `Mem_en`, `Mem_write_en`, `Mem_addr` and `Write_data`; the returned read data goes back on `Read_data`. It holds a byte-lane word RAM with one-cycle synchronous read latency and write-first bypass. It flags out-of-range accesses and, optionally, decodes a small memory-mapped I/O window.

## Interface
Parameters:
- `ADDR_W`, 10 — word-index width; RAM depth is 2^ADDR_W words of 32 bits.
- `MMIO_BASE`, 32'hBFAF_F000 — base byte address of the I/O window (used only with `DMEM_MMIO_EN`).

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `mem_en`  in  1  — request valid (core `Mem_en`).
- `mem_wen`  in  4  — byte write enables (core `Mem_write_en`); bit i writes byte lane i, bits [8i+7:8i]; 0 means read.
- `mem_addr`  in  32  — byte address (core `Mem_addr`); bits [1:0] are ignored.
- `mem_wdata`  in  32  — lane-aligned write data (core `Write_data`).
- `mem_rdata`  out  32  — read data (core `Read_data`).
- `rdata_valid`  out  1  — pulses for one cycle when `mem_rdata` carries the result of a read accepted the previous cycle.
- `addr_err`  out  1  — pulses for one cycle after an out-of-range request.
- `led_o`  out  16  — LED register (only with `DMEM_MMIO_EN`; otherwise tied 0).
- `sw_i`  in  16  — switch inputs (only with `DMEM_MMIO_EN`; otherwise ignored).

## Operation
- **Request acceptance:** a request is accepted at a rising edge when `mem_en`=1 and `rst`=0. With `mem_en`=0, no state changes except the cycle counter.
- **In-range RAM access:** `mem_addr[31:ADDR_W+2]`=0. The word index is `mem_addr[ADDR_W+1:2]`.
- **Write:** `mem_wen`≠0. Each enabled byte lane of the indexed word is updated; disabled lanes keep their old value.
- **Read:** every accepted request, including writes, registers a read of the indexed word.
- **Write-first bypass:** when a request both writes and reads the same word, `mem_rdata` returns the merged post-write word, with new lanes where enabled and old lanes elsewhere.
- **Out-of-range access:** not RAM and not MMIO.
  - Writes are suppressed.
  - `mem_rdata` is 0 next cycle.
  - `rdata_valid`=1 and `addr_err`=1 for that cycle.
- **Read-data hold:** `mem_rdata` holds its last value until the next accepted request.
- **Reset:** RAM contents are not cleared (undefined at power-up). A request presented in a reset cycle is dropped.
- **Output reset values:**
  - `mem_rdata` = 0
  - `rdata_valid` = 0
  - `addr_err` = 0
  - `led_o` = 0
  - cycle counter = 0

## Timing
- **Read latency:** exactly 1 cycle. A request accepted at edge N gives `mem_rdata`/`rdata_valid` valid after edge N until edge N+1. The core registers this into its W stage.
- **Write latency:** the write commits at edge N. A read of the same word at edge N+1 returns the new data, with no bubble.
- **Throughput:** back-to-back requests are accepted every cycle. There is no backpressure and no stall output.
- **`rdata_valid`:** high in cycle N+1 only if edge N accepted a request. It drops to 0 the cycle after an idle edge.
- **Reset priority:** `rst` asserted at edge N overrides any request and any pending result. All outputs read their reset values after edge N.

## Configuration
- **`DMEM_MMIO_EN` defined:** accesses with `mem_addr[31:4]` == `MMIO_BASE[31:4]` go to the I/O window instead of RAM.
  - Offset 0x0: LED register. Read/write; writes honour lanes 0–1 only; reads return {16'h0, `led_o`}.
  - Offset 0x4: switches. Read-only; reads return {16'h0, `sw_i`}, sampled at the accept edge; writes are ignored without error.
  - Offset 0x8: free-running 32-bit cycle counter. Increments every non-reset cycle and wraps 32'hFFFF_FFFF→0. Read-only; writes are ignored.
  - Offset 0xC: reads 0 and raises `addr_err`.
  - Latency is identical to RAM.
- **`DMEM_MMIO_EN` undefined:** no I/O window and no counter. `led_o` is tied 0. Window addresses fall under the normal range check, so they are out-of-range and raise `addr_err`.

## Test plan
- **Word write/read:** write 32'hDEAD_BEEF, `mem_wen`=4'hF, to 0x0000_0010; next cycle read 0x10. Required: `mem_rdata`=32'hDEAD_BEEF one cycle later, with `rdata_valid`=1.
- **Byte merge:** pre-load 0x10 = 32'h1122_3344; write 32'hAA00_0000 with `mem_wen`=4'b1000. Required: the same-cycle read result is 32'hAA22_3344, and a later read also returns 32'hAA22_3344.
- **Out of range and hold:** with `ADDR_W`=10, write 32'h5555_5555 to 0x0000_1000, then read 0x0000_1000. Required:
  - `addr_err` pulses one cycle per access and `mem_rdata`=0.
  - A read of 0x0000_0000 shows it unchanged.
  - An idle cycle follows with `rdata_valid`=0 and `mem_rdata` held.
- **Reset mid-stream:** issue a read of 0x10 with `rst`=1 on the same edge. Required: the next cycle shows `mem_rdata`=0 and `rdata_valid`=0. A read after reset deasserts returns the stored value (RAM not cleared).
- **MMIO (with `DMEM_MMIO_EN`):**
  - Write 32'h0000_00FF to 0xBFAF_F000 → `led_o`=16'h00FF.
  - Set `sw_i`=16'hA5A5 and read 0xBFAF_F004 → 32'h0000_A5A5.
  - Read 0xBFAF_F008 twice, 3 cycles apart → values differ by 3.
- **Without `DMEM_MMIO_EN`:** read 0xBFAF_F000. Required: `addr_err`=1, `mem_rdata`=0, and `led_o` stays 0.
